// File: rtl/counter_updown_mod_if.sv
// rtl/counter_updown_mod_if.sv - control and status bundle for the up/down modulo counter
interface counter_updown_mod_if #(
   parameter int BIT = 8
);
   logic           enable;
   logic           up;
   logic [BIT-1:0] step;
   logic           sat_mode;
   logic           load;
   logic [BIT-1:0] load_val;
   logic           ovf_clr;
   logic [BIT-1:0] count;
   logic           tc;
   logic           ovf;

   modport master (
      output enable, up, step, sat_mode, load, load_val, ovf_clr,
      input  count, tc, ovf
   );

   modport slave (
      input  enable, up, step, sat_mode, load, load_val, ovf_clr,
      output count, tc, ovf
   );
endinterface

// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - up/down modulo-MOD counter with wrap/saturate, load, tc pulse and sticky ovf
module counter_updown_mod #(
   parameter int BIT = 8,
   parameter int MOD = 2**BIT
) (
   input logic                 clk,
   input logic                 clr,
   counter_updown_mod_if.slave bus
);

   localparam int             MAX_I = MOD - 1;
   // One extra bit so count + step and count + MOD never lose a carry.
   localparam logic [BIT:0]   MOD_W = (BIT+1)'(MOD);
   localparam logic [BIT:0]   MAX_W = (BIT+1)'(MAX_I);

   logic [BIT-1:0] count_q, count_d;
   logic           tc_q, tc_d;
   logic           ovf_q, ovf_d;

   logic [BIT:0]   cnt_x;
   logic [BIT:0]   step_x;
   logic [BIT:0]   s_eff;
   logic [BIT:0]   sum;
   logic           up_cross;
   logic           dn_cross;
   logic           active;
   logic           bnd_event;

   // Clamp step, detect boundary crossing and compute the next count/flags.
   always_comb begin
      step_x    = {1'b0, bus.step};
      s_eff     = (step_x > MAX_W) ? MAX_W : step_x;
      cnt_x     = {1'b0, count_q};
      sum       = cnt_x + s_eff;
      up_cross  = (sum > MAX_W);
      dn_cross  = (s_eff > cnt_x);
      active    = bus.enable && !bus.load && (s_eff != '0);
      bnd_event = active && (bus.up ? up_cross : dn_cross);

      count_d = count_q;
      if (bus.load) begin
         count_d = ({1'b0, bus.load_val} > MAX_W) ? BIT'(MAX_I) : bus.load_val;
      end else if (active) begin
         if (bus.up) begin
            if (up_cross) begin
               count_d = bus.sat_mode ? BIT'(MAX_I) : BIT'(sum - MOD_W);
            end else begin
               count_d = BIT'(sum);
            end
         end else begin
            if (dn_cross) begin
               count_d = bus.sat_mode ? '0 : BIT'(cnt_x + MOD_W - s_eff);
            end else begin
               count_d = BIT'(cnt_x - s_eff);
            end
         end
      end

      // A boundary event outranks a same-cycle ovf_clr.
      tc_d  = bnd_event;
      ovf_d = bnd_event | (ovf_q & ~bus.ovf_clr);
   end

   // State register; clr clears everything at once without waiting for clk.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb/tb_counter_updown_mod.sv - self-checking bench for counter_updown_mod
module tb_counter_updown_mod;

   logic clk = 1'b0;
   logic clr = 1'b0;

   always #5 clk = ~clk;

   counter_updown_mod_if #(.BIT(8)) ia ();
   counter_updown_mod_if #(.BIT(4)) ib ();

   counter_updown_mod #(.BIT(8), .MOD(256)) dut_a (.clk(clk), .clr(clr), .bus(ia.slave));
   counter_updown_mod #(.BIT(4), .MOD(10))  dut_b (.clk(clk), .clr(clr), .bus(ib.slave));

   typedef struct {
      int    cnt;
      bit    tc;
      bit    ovf;
      string name;
   } exp_t;

   typedef struct {
      bit    en, up, sat, ld, oc;
      int    st, lv;
      int    ec;
      bit    et, eo;
      string nm;
   } vec_t;

   exp_t sbq[$];
   vec_t vt[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   maxc     = 0;

   task automatic check(input string nm, input int gc, input bit gt, input bit go,
                        input int ec, input bit et, input bit eo);
      n_checks++;
      if (gc != ec || gt != et || go != eo) begin
         n_err++;
         $display("FAIL %s: got count=%0d tc=%0d ovf=%0d, expected count=%0d tc=%0d ovf=%0d",
                  nm, gc, gt, go, ec, et, eo);
      end
   endtask

   task automatic pop_check(input int gc, input bit gt, input bit go);
      exp_t e;
      if (sbq.size() == 0) begin
         n_checks++;
         n_err++;
         $display("FAIL sb_empty: got count=%0d with no expected entry", gc);
      end else begin
         e = sbq.pop_front();
         check(e.name, gc, gt, go, e.cnt, e.tc, e.ovf);
      end
   endtask

   task automatic push_exp(input int ec, input bit et, input bit eo, input string nm);
      exp_t e;
      e.cnt  = ec;
      e.tc   = et;
      e.ovf  = eo;
      e.name = nm;
      sbq.push_back(e);
   endtask

   task automatic cyc_a(input bit en, input bit up, input bit sat, input bit ld, input bit oc,
                        input int st, input int lv, input int ec, input bit et, input bit eo,
                        input string nm);
      ia.enable = en; ia.up = up; ia.sat_mode = sat; ia.load = ld; ia.ovf_clr = oc;
      ia.step = 8'(st); ia.load_val = 8'(lv);
      push_exp(ec, et, eo, nm);
      @(posedge clk);
      #1;
      pop_check(int'(ia.count), ia.tc, ia.ovf);
   endtask

   task automatic cyc_b(input bit en, input bit up, input bit sat, input bit ld, input bit oc,
                        input int st, input int lv, input int ec, input bit et, input bit eo,
                        input string nm);
      ib.enable = en; ib.up = up; ib.sat_mode = sat; ib.load = ld; ib.ovf_clr = oc;
      ib.step = 4'(st); ib.load_val = 4'(lv);
      push_exp(ec, et, eo, nm);
      @(posedge clk);
      #1;
      if (int'(ib.count) > maxc) maxc = int'(ib.count);
      pop_check(int'(ib.count), ib.tc, ib.ovf);
   endtask

   task automatic add_vec(input bit en, input bit up, input bit sat, input bit ld, input bit oc,
                          input int st, input int lv, input int ec, input bit et, input bit eo,
                          input string nm);
      vec_t v;
      v.en = en; v.up = up; v.sat = sat; v.ld = ld; v.oc = oc;
      v.st = st; v.lv = lv; v.ec = ec; v.et = et; v.eo = eo; v.nm = nm;
      vt.push_back(v);
   endtask

   // Reference behaviour of one clock edge for a counter of range 0..mod-1.
   function automatic void mstep(input int mod, input int c, input bit ovf,
                                 input bit en, input bit up, input bit sat, input bit ld, input bit oc,
                                 input int st, input int lv,
                                 output int nc, output bit ntc, output bit novf);
      int s;
      int l;
      bit ev;
      s  = (st > mod - 1) ? mod - 1 : st;
      l  = (lv > mod - 1) ? mod - 1 : lv;
      ev = 1'b0;
      nc = c;
      if (ld) begin
         nc = l;
      end else if (en && s != 0) begin
         if (up) begin
            if (c + s > mod - 1) begin
               ev = 1'b1;
               nc = sat ? mod - 1 : c + s - mod;
            end else begin
               nc = c + s;
            end
         end else begin
            if (s > c) begin
               ev = 1'b1;
               nc = sat ? 0 : c + mod - s;
            end else begin
               nc = c - s;
            end
         end
      end
      ntc  = ev;
      novf = ev ? 1'b1 : (oc ? 1'b0 : ovf);
   endfunction

   initial begin
      int mc;
      bit mo;
      int nc;
      bit nt;
      bit no;
      bit r_en, r_up, r_sat, r_ld, r_oc;
      int r_st, r_lv;

      // Vectors for the modulo-10 instance: step-3 wrap, down saturate with ovf_clr race, load/step clamping.
      add_vec(1,1,0,0,0, 3, 0,  3,0,0, "up3_e1");
      add_vec(1,1,0,0,0, 3, 0,  6,0,0, "up3_e2");
      add_vec(1,1,0,0,0, 3, 0,  9,0,0, "up3_e3");
      add_vec(1,1,0,0,0, 3, 0,  2,1,1, "up3_wrap");
      add_vec(1,1,0,0,0, 3, 0,  5,0,1, "up3_after_wrap");
      add_vec(0,0,0,0,1, 0, 0,  5,0,0, "ovf_clr");
      add_vec(1,0,1,1,0, 4, 6,  6,0,0, "load6");
      add_vec(1,0,1,0,0, 4, 0,  2,0,0, "dn4");
      add_vec(1,0,1,0,0, 4, 0,  0,1,1, "dn4_sat");
      add_vec(1,0,1,0,1, 4, 0,  0,1,1, "dn4_sat_clr_race");
      add_vec(0,0,1,0,0, 4, 0,  0,0,1, "hold_tc_drop");
      add_vec(0,0,0,0,1, 0, 0,  0,0,0, "ovf_clr2");
      add_vec(1,1,0,1,0, 3,15,  9,0,0, "load_clamp");
      add_vec(1,1,0,0,0, 0, 0,  9,0,0, "step0");
      add_vec(1,1,0,0,0,15, 0,  8,1,1, "step_clamp_up_wrap");
      add_vec(1,0,0,0,0,15, 0,  9,1,1, "step_clamp_dn_wrap");
      add_vec(1,1,1,0,0, 1, 0,  9,1,1, "sat_at_limit");
      add_vec(1,1,0,1,0, 5, 3,  3,0,1, "load_no_event");
      add_vec(0,1,0,0,0, 5, 0,  3,0,1, "hold");

      ia.enable = 0; ia.up = 0; ia.sat_mode = 0; ia.load = 0; ia.ovf_clr = 0;
      ia.step = '0; ia.load_val = '0;
      ib.enable = 0; ib.up = 0; ib.sat_mode = 0; ib.load = 0; ib.ovf_clr = 0;
      ib.step = '0; ib.load_val = '0;

      @(posedge clk);
      #1;
      check("reset_a", int'(ia.count), ia.tc, ia.ovf, 0, 0, 0);
      check("reset_b", int'(ib.count), ib.tc, ib.ovf, 0, 0, 0);
      clr = 1'b1;

      // Full 8-bit wrap: 257 edges from zero.
      for (int k = 1; k <= 257; k++) begin
         cyc_a(1,1,0,0,0, 1, 0, k % 256, (k == 256), (k >= 256), "wrap256");
      end

      // Asynchronous reset in the middle of counting at 200.
      cyc_a(1,1,0,1,0, 1,199, 199,0,1, "load199");
      cyc_a(1,1,0,0,0, 1,  0, 200,0,1, "count200");
      @(negedge clk);
      #1;
      clr = 1'b0;
      #1;
      check("rst_async_a", int'(ia.count), ia.tc, ia.ovf, 0, 0, 0);
      #1;
      clr = 1'b1;
      cyc_a(1,1,0,0,0, 1, 0, 1,0,0, "resume1");
      cyc_a(1,1,0,0,0, 1, 0, 2,0,0, "resume2");
      cyc_a(1,1,0,0,0, 1, 0, 3,0,0, "resume3");
      ia.enable = 0;

      foreach (vt[i]) begin
         cyc_b(vt[i].en, vt[i].up, vt[i].sat, vt[i].ld, vt[i].oc, vt[i].st, vt[i].lv,
               vt[i].ec, vt[i].et, vt[i].eo, vt[i].nm);
      end

      // Reset while a boundary event is pending: update discarded, no tc afterwards.
      ib.enable = 1; ib.up = 0; ib.step = 4'd5; ib.sat_mode = 0; ib.load = 0; ib.ovf_clr = 0;
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("rst_async_b", int'(ib.count), ib.tc, ib.ovf, 0, 0, 0);
      @(posedge clk);
      #1;
      check("rst_held_b", int'(ib.count), ib.tc, ib.ovf, 0, 0, 0);
      clr = 1'b1;
      cyc_b(0,0,0,0,0, 5, 0, 0,0,0, "no_tc_after_rst");

      // Randomised run against the reference model.
      mc = 0;
      mo = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         r_en  = ($urandom_range(0, 3) != 0);
         r_up  = 1'($urandom_range(0, 1));
         r_sat = 1'($urandom_range(0, 1));
         r_ld  = ($urandom_range(0, 7) == 0);
         r_oc  = ($urandom_range(0, 7) == 0);
         r_st  = $urandom_range(0, 15);
         r_lv  = $urandom_range(0, 15);
         mstep(10, mc, mo, r_en, r_up, r_sat, r_ld, r_oc, r_st, r_lv, nc, nt, no);
         cyc_b(r_en, r_up, r_sat, r_ld, r_oc, r_st, r_lv, nc, nt, no, "rand");
         mc = nc;
         mo = no;
      end

      n_checks++;
      if (maxc >= 10) begin
         n_err++;
         $display("FAIL count_lt_mod: max count=%0d, required < 10", maxc);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/counter_updown_mod.md
COUNTER_UPDOWN_MOD -- requirements
Module: counter_updown_mod

Interface
REQ-001 Parameter BIT, default 8, counter and data width in bits (BIT >= 2).
REQ-002 Parameter MOD, default 2**BIT, count range 0..MOD-1 (2 <= MOD <= 2**BIT).
REQ-003 clk  input  1  clock; all state changes on rising edge except reset.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  count enable; 0 holds count (load still honoured).
REQ-006 up  input  1  direction: 1 = count up, 0 = count down.
REQ-007 step  input  BIT  increment/decrement magnitude per enabled cycle.
REQ-008 sat_mode  input  1  boundary mode: 0 = wrap modulo MOD, 1 = saturate.
REQ-009 load  input  1  synchronous parallel load strobe.
REQ-010 load_val  input  BIT  value captured on load.
REQ-011 ovf_clr  input  1  synchronous clear of sticky ovf.
REQ-012 count  output  BIT  registered count value.
REQ-013 tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 ovf  output  1  registered sticky boundary-event flag.

Function
REQ-015 The effective step SHALL be min(step, MOD-1); an effective step of 0 SHALL leave count unchanged and raise no event.
REQ-016 The effective load value SHALL be min(load_val, MOD-1).
REQ-017 Priority per cycle SHALL be load > enable > hold.
REQ-018 On load, count SHALL take the effective load value on the next edge, regardless of enable; tc SHALL be 0 that cycle, and ovf SHALL NOT be set by the load.
REQ-019 Up, no boundary (count + s <= MOD-1): count SHALL become count + s on the next edge.
REQ-020 Down, no boundary (s <= count): count SHALL become count - s on the next edge.
REQ-021 Up crossing (count + s > MOD-1), sat_mode=0: count SHALL become count + s - MOD; sat_mode=1: count SHALL become MOD-1.
REQ-022 Down crossing (s > count), sat_mode=0: count SHALL become count + MOD - s; sat_mode=1: count SHALL become 0.
REQ-023 Intermediate arithmetic SHALL use BIT+1 bits so that no carry or borrow is lost for any parameter legal value.
REQ-024 A boundary event is any enabled, non-load cycle satisfying REQ-021 or REQ-022, including saturate-mode cycles where count is already at the limit and stays there.
REQ-025 tc SHALL be 1 for exactly the cycle following each boundary event and 0 otherwise; back-to-back events SHALL give tc continuously high.
REQ-026 ovf SHALL be set on the edge following a boundary event and held until cleared.
REQ-027 ovf_clr SHALL clear ovf on the next edge; when ovf_clr and a boundary event occur in the same cycle, set SHALL win.
REQ-028 up, step, sat_mode, and load_val SHALL be sampled only on the edge where they take effect; mid-run changes SHALL apply from the next enabled cycle with no glitch on count.
REQ-029 count SHALL never hold a value >= MOD.

Reset
REQ-030 clr low SHALL immediately force count = 0, tc = 0, and ovf = 0, independent of clk.
REQ-031 While clr is low, all inputs SHALL be ignored; the first edge after clr rises SHALL evaluate normally from count = 0.
REQ-032 Reset asserted mid-operation (including during load or a boundary event) SHALL discard the pending update, and no tc pulse SHALL appear after release.

Verification
REQ-033 BIT=8, MOD=256, up=1, step=1, sat_mode=0, enable=1 from reset, 257 edges -> count 0..255, then 0, then 1; tc high only in the cycle after 255->0; ovf=1 after the wrap.
REQ-034 BIT=4, MOD=10, up=1, step=3, wrap, start 0 -> sequence 3,6,9,2,5; tc pulses after 9->2.
REQ-035 MOD=10, down, step=4, sat_mode=1, load 6 -> 6,2,0,0; tc high on the cycle after each of the last two edges; ovf sets; ovf_clr with a simultaneous event keeps ovf=1.
REQ-036 MOD=10, load_val=15 with enable=1 and load=1 -> count=9, no tc, ovf unchanged; then step=0 with enable=1 -> count stays 9, no tc.
REQ-037 Counting at count=200 with ovf=1, clr pulsed low between edges -> count=0, tc=0, ovf=0 immediately; resumes 1,2,... after release.
REQ-038 Randomised up/step/mode/load for 10k cycles against a reference model -> count, tc, and ovf match every cycle, and count < MOD always.
